// File: rtl/bin2bcd_seq_pkg.sv
// Shared constants and FSM encoding for the sequential binary-to-BCD converter.
package bin2bcd_seq_pkg;

  localparam int BIN_W  = 20;
  localparam int DIGITS = 6;
  localparam int BCD_W  = 4 * DIGITS;

  localparam logic [BIN_W-1:0] BCD_MAX = 20'd999999;
  localparam logic [BCD_W-1:0] SAT_BCD = 24'h999999;

  localparam int              CNT_W    = 5;
  localparam logic [CNT_W-1:0] ITER_CNT = 5'd20;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/bin2bcd_if.sv
// Request/result bundle between a requester (master) and the converter (slave).
interface bin2bcd_if
  import bin2bcd_seq_pkg::*;
  ;
  logic             start;
  logic [BIN_W-1:0] bin_in;
  logic             busy;
  logic             done;
  logic [BCD_W-1:0] bcd_out;
  logic             ovf;

  modport master (output start, bin_in, input busy, done, bcd_out, ovf);
  modport slave  (input start, bin_in, output busy, done, bcd_out, ovf);
endinterface

// File: rtl/bin2bcd_seq_bcd_add3.sv
// Double-dabble digit correction: a digit of 5 or more gets 3 added before the shift.
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);
  assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential 20-bit binary to 6-digit BCD converter, one shift per clock.
// Build option BIN2BCD_SAT_EN: out-of-range inputs read 999999 instead of value mod 1e6.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   ST_IDLE  | waiting for start; operand latched on accept
//   ST_SHIFT | 20 add-3/shift iterations on {work, bin_sr}
//   ST_DONE  | publish result and ovf, pulse done
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int BIN_W  = 20,
  parameter int DIGITS = 6
) (
  input logic       clk,
  input logic       rst,
  bin2bcd_if.slave  bus
);

  localparam int W = 4 * DIGITS;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     work;
  logic [W-1:0]     adj;
  logic [W-1:0]     result;
  logic [BIN_W-1:0] bin_sr;
  logic             ovf_pend;
  logic [W-1:0]     bcd_q;
  logic             ovf_q;
  logic             done_q;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bcd_add3 u_add3 (
      .din  (work[4*g +: 4]),
      .dout (adj[4*g +: 4])
    );
  end

  // The carry out of the top digit is dropped, so the plain build yields value mod 1e6.
  always_comb begin
    result = work;
`ifdef BIN2BCD_SAT_EN
    if (ovf_pend) result = SAT_BCD;
`else
    result = work;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      work     <= '0;
      bin_sr   <= '0;
      ovf_pend <= 1'b0;
      bcd_q    <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            bin_sr   <= bus.bin_in;
            work     <= '0;
            cnt      <= ITER_CNT;
            ovf_pend <= (bus.bin_in > BCD_MAX);
            state    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          work   <= {adj[W-2:0], bin_sr[BIN_W-1]};
          bin_sr <= {bin_sr[BIN_W-2:0], 1'b0};
          cnt    <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= ST_DONE;
        end
        ST_DONE: begin
          bcd_q  <= result;
          ovf_q  <= ovf_pend;
          done_q <= 1'b1;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy    = (state != ST_IDLE);
  assign bus.done    = done_q;
  assign bus.bcd_out = bcd_q;
  assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: stimulus pushes expected results, a monitor pops on done.
module tb_bin2bcd_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  logic [24:0] sb_q[$];
  int          done_cycs[$];

`ifdef BIN2BCD_SAT_EN
  localparam logic [23:0] EXP_1M  = 24'h999999;
  localparam logic [23:0] EXP_MAX = 24'h999999;
`else
  localparam logic [23:0] EXP_1M  = 24'h000000;
  localparam logic [23:0] EXP_MAX = 24'h048575;
`endif

  bin2bcd_if bus ();

  bin2bcd_seq #(.BIN_W(20), .DIGITS(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && bus.done === 1'b1) begin
      done_cycs.push_back(cyc);
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done: got bcd %0h ovf %0b expected no done", bus.bcd_out, bus.ovf);
      end else begin
        logic [24:0] e;
        e = sb_q.pop_front();
        check("result", {7'd0, bus.bcd_out, bus.ovf}, {7'd0, e});
      end
    end
  end

  task automatic run_conv(input logic [19:0] val, input logic [23:0] eb, input logic e_ovf);
    int busy_n;
    busy_n = 0;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.bin_in = val;
    sb_q.push_back({eb, e_ovf});
    @(negedge clk);
    bus.start  = 1'b0;
    bus.bin_in = ~val;
    while (bus.busy === 1'b1 && busy_n < 40) begin
      busy_n++;
      @(negedge clk);
    end
    check("busy_cycles", 32'(busy_n), 32'd21);
    check("done_at_k21", 32'(bus.done), 32'd1);
    @(negedge clk);
    check("done_one_cycle", 32'(bus.done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("bcd_hold", 32'(bus.bcd_out), 32'(eb));
    check("ovf_hold", 32'(bus.ovf), 32'(e_ovf));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.start  = 1'b1;
    bus.bin_in = 20'd77;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_bcd", 32'(bus.bcd_out), 32'd0);
    check("rst_ovf", 32'(bus.ovf), 32'd0);
    rst = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("start_in_rst_ignored", 32'(bus.busy), 32'd0);

    run_conv(20'd0,       24'h000000, 1'b0);
    run_conv(20'd123456,  24'h123456, 1'b0);
    run_conv(20'd999999,  24'h999999, 1'b0);
    run_conv(20'd1000000, EXP_1M,     1'b1);
    run_conv(20'd1048575, EXP_MAX,    1'b1);
    run_conv(20'd9,       24'h000009, 1'b0);
    run_conv(20'd500000,  24'h500000, 1'b0);

    // start during conversion must be ignored
    @(negedge clk);
    bus.start  = 1'b1;
    bus.bin_in = 20'd42;
    sb_q.push_back({24'h000042, 1'b0});
    @(negedge clk);
    bus.start  = 1'b0;
    repeat (3) @(negedge clk);
    bus.start  = 1'b1;
    bus.bin_in = 20'd7;
    @(negedge clk);
    bus.start  = 1'b0;
    repeat (60) @(negedge clk);
    check("ignored_start_bcd", 32'(bus.bcd_out), 32'h000042);
    check("ignored_start_queue", 32'(sb_q.size()), 32'd0);

    // abort mid-conversion with reset
    @(negedge clk);
    bus.start  = 1'b1;
    bus.bin_in = 20'd654321;
    @(negedge clk);
    bus.start  = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_bcd", 32'(bus.bcd_out), 32'd0);
    check("abort_ovf", 32'(bus.ovf), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("abort_no_done_bcd", 32'(bus.bcd_out), 32'd0);
    run_conv(20'd55, 24'h000055, 1'b0);

    // back-to-back with start held high
    begin
      int c0;
      repeat (5) @(negedge clk);
      done_cycs.delete();
      c0 = cyc;
      bus.start  = 1'b1;
      bus.bin_in = 20'd10;
      repeat (3) sb_q.push_back({24'h000010, 1'b0});
      while (cyc < c0 + 45) @(negedge clk);
      bus.start = 1'b0;
      repeat (40) @(negedge clk);
      check("b2b_done_count", 32'(done_cycs.size()), 32'd3);
      if (done_cycs.size() == 3) begin
        check("b2b_done0", 32'(done_cycs[0] - c0), 32'd22);
        check("b2b_done1", 32'(done_cycs[1] - c0), 32'd44);
        check("b2b_done2", 32'(done_cycs[2] - c0), 32'd66);
      end
    end

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
